// File: rtl/key_expansion_ctrl_pkg.sv
// Shared constants for the AES-128 key-expansion controller: sizes, FSM encoding,
// the forward S-box and the round constant table.
package key_expansion_ctrl_pkg;

   localparam int NR    = 10;
   localparam int KEY_W = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Byte x of the forward S-box lives at bits [8x : 8x+7].
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      case (r)
         4'd0:    c = 8'h01;
         4'd1:    c = 8'h02;
         4'd2:    c = 8'h04;
         4'd3:    c = 8'h08;
         4'd4:    c = 8'h10;
         4'd5:    c = 8'h20;
         4'd6:    c = 8'h40;
         4'd7:    c = 8'h80;
         4'd8:    c = 8'h1b;
         4'd9:    c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/key_expansion_ctrl_key_scheduler.sv
// One combinational AES-128 key-schedule round: derives round key r+1 from round key r.
module key_scheduler
   import key_expansion_ctrl_pkg::*;
(
   input  logic [0:3]       round_in,
   input  logic [0:KEY_W-1] key_in,
   output logic [0:KEY_W-1] out
);

   logic [0:31] w0, w1, w2, w3;
   logic [0:31] rot, sub, temp;
   logic [0:31] n0, n1, n2, n3;

   always_comb begin
      w0  = key_in[0:31];
      w1  = key_in[32:63];
      w2  = key_in[64:95];
      w3  = key_in[96:127];
      rot = {w3[8:31], w3[0:7]};
      sub = '0;
      for (int j = 0; j < 4; j++) begin
         sub[8*j +: 8] = sbox(rot[8*j +: 8]);
      end
      temp = sub ^ {rcon(round_in), 24'h000000};
      // Each new word chains on the one just produced.
      n0  = w0 ^ temp;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      out = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/key_expansion_ctrl.sv
// Iterates a single key_scheduler once per clock to fill an 11-entry round-key
// register file, then serves the keys through a combinational read port.
module key_expansion_ctrl
   import key_expansion_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_in,
   input  logic [0:KEY_W-1] key_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             keys_valid_out,
   input  logic [3:0]       rd_round_in,
   output logic [0:KEY_W-1] rd_key_out
);

   state_t           state;
   logic [3:0]       cnt;
   logic [0:KEY_W-1] rk [0:NR];
   logic [0:KEY_W-1] sched_key;
   logic [0:KEY_W-1] sched_out;

   // The scheduler always works on the newest key written so far.
   always_comb begin
      sched_key = rk[0];
      for (int i = 0; i < NR; i++) begin
         if (cnt == 4'(i)) sched_key = rk[i];
      end
   end

   key_scheduler u_sched (
      .round_in (cnt),
      .key_in   (sched_key),
      .out      (sched_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         busy_out       <= 1'b0;
         done_out       <= 1'b0;
         keys_valid_out <= 1'b0;
         for (int i = 0; i <= NR; i++) rk[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_out <= 1'b0;
               if (start_in) begin
                  rk[0]          <= key_in;
                  cnt            <= '0;
                  keys_valid_out <= 1'b0;
                  busy_out       <= 1'b1;
                  state          <= EXPAND;
               end
            end
            EXPAND: begin
               for (int i = 1; i <= NR; i++) begin
                  if (cnt == 4'(i - 1)) rk[i] <= sched_out;
               end
               // cnt parks at NR-1 so it never leaves its legal range.
               if (cnt == 4'(NR - 1)) begin
                  done_out <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               done_out       <= 1'b0;
               keys_valid_out <= 1'b1;
               busy_out       <= 1'b0;
               state          <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd_key_out = '0;
      for (int i = 0; i <= NR; i++) begin
         if (rd_round_in == 4'(i)) rd_key_out = rk[i];
      end
   end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Bench for key_expansion_ctrl: word-level AES-128 expansion model with an
// arithmetically derived S-box, timeline model of the controller, per-cycle compare.
module tb_key_expansion_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key = '0;
   logic [3:0]   rd = '0;
   logic         busy, done, kv;
   logic [127:0] rd_key;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   bit rand_rd = 1'b0;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   key_expansion_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_in       (start),
      .key_in         (key),
      .busy_out       (busy),
      .done_out       (done),
      .keys_valid_out (kv),
      .rd_round_in    (rd),
      .rd_key_out     (rd_key)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] sbox_m [256];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in;
      logic [7:0] b = b_in;
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic void build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t  = t ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Timeline view: accept at age 0, rk[n] lands at age n, done visible after age 10,
   // keys valid from age 11, next accept possible from age 12.
   bit           active = 1'b0;
   int           age = 0;
   logic [127:0] acc_key = '0;
   logic [127:0] stored [11];
   logic         m_busy = 1'b0, m_done = 1'b0, m_kv = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         age    <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_kv   <= 1'b0;
         for (int i = 0; i < 11; i++) stored[i] <= '0;
      end else if ((!active || age >= 11) && start) begin
         active    <= 1'b1;
         age       <= 0;
         acc_key   <= key;
         stored[0] <= key;
         m_kv      <= 1'b0;
         m_busy    <= 1'b1;
         m_done    <= 1'b0;
      end else if (active) begin
         age <= age + 1;
         if (age + 1 <= 10) stored[age+1] <= model_rk(acc_key, age + 1);
         if (age + 1 == 11) m_kv <= 1'b1;
         m_busy <= (age + 1 <= 10);
         m_done <= (age + 1 == 10);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 128'(busy), 128'(m_busy));
         check("done", 128'(done), 128'(m_done));
         check("keys_valid", 128'(kv), 128'(m_kv));
         check("rd_key", rd_key, (rd <= 4'd10) ? stored[rd] : 128'h0);
      end
   end

   // ---------------- drivers ----------------
   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rd) rd = 4'($urandom_range(0, 15));
   endtask

   task automatic start_exp(input logic [127:0] k);
      start = 1'b1;
      key   = k;
      tick();
      start = 1'b0;
      key   = rand_key();
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done) begin
            n = i;
            break;
         end
      end
      if (n < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout act=none exp=done_out within 40 cycles");
      end
   endtask

   task automatic read_check(input string name, input logic [3:0] r, input logic [127:0] exp);
      rd = r;
      #1;
      check(name, rd_key, exp);
   endtask

   int n, ndone, nacc;
   logic prev_busy;

   initial begin
      build_sbox();
      check("model_fips_rk1", model_rk(FIPS_KEY, 1), FIPS_RK1);
      check("model_fips_rk10", model_rk(FIPS_KEY, 10), FIPS_RK10);
      check("model_zero_rk1", model_rk(128'h0, 1), ZERO_RK1);
      check("model_zero_rk10", model_rk(128'h0, 10), ZERO_RK10);

      // reset state
      #12;
      check("reset_busy", 128'(busy), 128'h0);
      check("reset_done", 128'(done), 128'h0);
      check("reset_kv", 128'(kv), 128'h0);
      read_check("reset_rk5", 4'd5, 128'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      // FIPS-197 key, latency
      start_exp(FIPS_KEY);
      wait_done(n);
      check("done_latency", 128'(n), 128'd10);
      tick();
      check("kv_rise", 128'(kv), 128'h1);
      read_check("fips_rk1", 4'd1, FIPS_RK1);
      read_check("fips_rk10", 4'd10, FIPS_RK10);

      // all-zero key
      start_exp(128'h0);
      wait_done(n);
      check("zero_latency", 128'(n), 128'd10);
      tick();
      read_check("zero_rk1", 4'd1, ZERO_RK1);
      read_check("zero_rk10", 4'd10, ZERO_RK10);

      // starts while busy are ignored
      start_exp(FIPS_KEY);
      ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         start = (c == 3 || c == 7);
         key   = rand_key();
         tick();
         if (done) ndone++;
      end
      start = 1'b0;
      check("single_done", 128'(ndone), 128'd1);
      read_check("ignored_rk10", 4'd10, FIPS_RK10);

      // reset in the middle of expansion
      start_exp(128'h0);
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 128'(busy), 128'h0);
      check("midrst_done", 128'(done), 128'h0);
      check("midrst_kv", 128'(kv), 128'h0);
      for (int r = 0; r < 16; r++) read_check("midrst_rk", 4'(r), 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start_exp(FIPS_KEY);
      wait_done(n);
      check("rerun_latency", 128'(n), 128'd10);
      tick();
      read_check("rerun_rk1", 4'd1, FIPS_RK1);
      read_check("rerun_rk10", 4'd10, FIPS_RK10);

      // full read sweep
      for (int r = 0; r < 16; r++) begin
         read_check("sweep", 4'(r), (r <= 10) ? model_rk(FIPS_KEY, r) : 128'h0);
         tick();
      end

      // start held high for 30 cycles with a changing key
      rand_rd   = 1'b1;
      nacc      = 0;
      prev_busy = busy;
      start     = 1'b1;
      for (int i = 0; i < 30; i++) begin
         key = rand_key();
         tick();
         if (busy && !prev_busy) nacc++;
         prev_busy = busy;
      end
      start = 1'b0;
      check("held_accepts", 128'(nacc), 128'd3);
      repeat (15) tick();

      // random traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 7) == 0);
         key   = rand_key();
         if ($urandom_range(0, 99) == 0) begin
            #2;
            rst_n = 1'b0;
            #4;
            rst_n = 1'b1;
         end
         tick();
      end
      start = 1'b0;
      repeat (15) tick();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
